// File: rtl/msk_pkg.sv
// Shared constants and helpers for the masked-AND scheduler.
package msk_pkg;

  // Cycles from gadget operand b to a valid gadget product
  localparam int unsigned GADGET_LAT = 2;
  // Cycles from issue to response presentation
  localparam int unsigned SCHED_LAT = 4;

  // Fresh random bits consumed by one d-share AND gadget
  function automatic int unsigned n_rnd(input int unsigned shares);
    return shares * (shares - 1) / 2;
  endfunction

  // Width of a requester index (at least one bit)
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msk_rr_arb.sv
// Requester arbiter: one-hot grant plus index when enabled.
// MSK_AND_SCHED_RR_EN selects round-robin; default is fixed lowest-index priority.
module msk_rr_arb
  import msk_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic                      en,
  output logic [N_REQ-1:0]          grant,
  output logic [id_w(N_REQ)-1:0]    idx
);

  localparam int unsigned IW = id_w(N_REQ);

  logic found;

`ifdef MSK_AND_SCHED_RR_EN
  logic [IW-1:0] ptr_q;

  // Search upward from the pointer, wrapping around
  always_comb begin
    int unsigned j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (32'(ptr_q) + 32'(k)) % N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    grant = (en && found) ? (N_REQ'(1) << idx) : '0;
  end

  // Pointer moves just past the winner on every issue
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en && found) begin
      ptr_q <= (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
    end
  end
`else
  // Fixed priority carries no state
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Lowest set index wins: scan downward so the last hit is the lowest
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        found = 1'b1;
        idx   = IW'(k);
      end
    end
    grant = (en && found) ? (N_REQ'(1) << idx) : '0;
  end
`endif

endmodule

// File: rtl/msk_and_sched.sv
// Scheduler feeding a shared d-share masked AND gadget from N_REQ requesters.
// Optional round-robin arbitration via MSK_AND_SCHED_RR_EN (fixed priority otherwise).
module msk_and_sched
  import msk_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned N_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*d-1:0]        req_a,
  input  logic [N_REQ*d-1:0]        req_b,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  input  logic [n_rnd(d)-1:0]       rnd_data,
  output logic [d-1:0]              g_ina,
  output logic [d-1:0]              g_inb,
  output logic [n_rnd(d)-1:0]       g_rnd,
  input  logic [d-1:0]              g_out,
  output logic                      resp_valid,
  output logic [id_w(N_REQ)-1:0]    resp_id,
  output logic [d-1:0]              resp_data,
  output logic [1:0]                inflight
);

  localparam int unsigned IW = id_w(N_REQ);
  localparam int unsigned NR = n_rnd(d);
  // Tracked stages between issue and response
  localparam int unsigned VD = SCHED_LAT - 1;

  logic              issue;
  logic [N_REQ-1:0]  grant;
  logic [IW-1:0]     gidx;
  logic [d-1:0]      sel_a;
  logic [d-1:0]      sel_b;

  logic [d-1:0]      inb_q;
  logic [NR-1:0]     rnd_q;
  logic [d-1:0]      a_q [GADGET_LAT];
  logic [VD-1:0]     vld_q;
  logic [IW-1:0]     id_q [VD];
  logic              resp_valid_q;
  logic [IW-1:0]     resp_id_q;
  logic [d-1:0]      resp_data_q;

  assign issue     = (|req_valid) & rnd_valid & ~rst;
  assign rnd_ready = issue;
  assign req_ready = grant;

  msk_rr_arb #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (issue),
    .grant (grant),
    .idx   (gidx)
  );

  // Select the granted requester's sharings; a and b stay on separate paths
  always_comb begin
    sel_a = req_a[32'(gidx) * d +: d];
    sel_b = req_b[32'(gidx) * d +: d];
  end

  // Gadget operand staging; idle slots load zeros so no stale share lingers
  always_ff @(posedge clk) begin
    if (rst) begin
      inb_q <= '0;
      rnd_q <= '0;
      for (int k = 0; k < GADGET_LAT; k++) a_q[k] <= '0;
    end else begin
      inb_q  <= issue ? sel_b : '0;
      rnd_q  <= issue ? rnd_data : '0;
      a_q[0] <= issue ? sel_a : '0;
      for (int k = 1; k < GADGET_LAT; k++) a_q[k] <= a_q[k-1];
    end
  end

  // Valid/id tracking pipeline and response capture of the gadget product
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      for (int k = 0; k < VD; k++) id_q[k] <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      vld_q        <= {vld_q[VD-2:0], issue};
      id_q[0]      <= issue ? gidx : '0;
      for (int k = 1; k < VD; k++) id_q[k] <= id_q[k-1];
      resp_valid_q <= vld_q[VD-1];
      resp_id_q    <= vld_q[VD-1] ? id_q[VD-1] : '0;
      resp_data_q  <= vld_q[VD-1] ? g_out : '0;
    end
  end

  // Operations in flight = occupied tracking stages (at most 3)
  always_comb begin
    inflight = '0;
    for (int k = 0; k < VD; k++) inflight = inflight + 2'(vld_q[k]);
  end

  assign g_inb      = inb_q;
  assign g_rnd      = rnd_q;
  assign g_ina      = a_q[GADGET_LAT-1];
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_msk_and_sched.sv
// Self-checking bench for msk_and_sched (d=3, four requesters) with a gadget model
// and a cycle-indexed reference of issues, grants and responses.
module tb_msk_and_sched;

  localparam int unsigned D    = 3;
  localparam int unsigned NQ   = 4;
  localparam int unsigned NRND = D * (D - 1) / 2;
  localparam int unsigned IW   = 2;
  localparam int          MAXC = 2048;
`ifdef MSK_AND_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NQ-1:0]     req_valid;
  logic [NQ-1:0]     req_ready;
  logic [NQ*D-1:0]   req_a;
  logic [NQ*D-1:0]   req_b;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [NRND-1:0]   rnd_data;
  logic [D-1:0]      g_ina;
  logic [D-1:0]      g_inb;
  logic [NRND-1:0]   g_rnd;
  logic [D-1:0]      g_out;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [D-1:0]      resp_data;
  logic [1:0]        inflight;

  always #5 clk = ~clk;

  msk_and_sched #(
    .d     (D),
    .N_REQ (NQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .rnd_data   (rnd_data),
    .g_ina      (g_ina),
    .g_inb      (g_inb),
    .g_rnd      (g_rnd),
    .g_out      (g_out),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .inflight   (inflight)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ptr    = 0;

  // Reference history, indexed by cycle
  bit              iss [MAXC];
  int              gi  [MAXC];
  logic [D-1:0]    ha  [MAXC];
  logic [D-1:0]    hb  [MAXC];
  logic [NRND-1:0] hr  [MAXC];
  logic [D-1:0]    hgo [MAXC];
  logic [D-1:0]    oa  [MAXC];
  logic [D-1:0]    ob  [MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // First requesting index at or after p, wrapping; -1 if none
  function automatic int pick(input logic [NQ-1:0] rv, input int p);
    for (int k = 0; k < NQ; k++) begin
      int j = (p + k) % NQ;
      if (rv[j]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: drive at negedge, check, record, advance
  task automatic step(input logic r, input logic [NQ-1:0] rv, input logic rdv);
    logic [D-1:0] s;
    logic         p;
    bit           e_iss;
    bit           e_rv;
    int           g;
    int           c;
    int           inf;
    c = cyc;
    rst       = r;
    req_valid = rv;
    rnd_valid = rdv;
    for (int i = 0; i < NQ; i++) begin
      req_a[i*D +: D] = D'($urandom);
      req_b[i*D +: D] = D'($urandom);
    end
    rnd_data = NRND'($urandom);
    // Gadget model: product of what the DUT presented, freshly re-shared
    p = (c >= 2) ? ((^oa[c-1]) & (^ob[c-2])) : 1'b0;
    s = D'($urandom);
    s[0] = (^s[D-1:1]) ^ p;
    g_out = s;
    #1;
    e_iss = !r && (rv != '0) && rdv;
    g = pick(rv, RR ? ptr : 0);
    chk("rnd_ready", 32'(rnd_ready), 32'(e_iss));
    chk("req_ready", 32'(req_ready), e_iss ? (32'd1 << g) : 32'd0);
    chk("g_inb", 32'(g_inb), (c >= 1 && iss[c-1]) ? 32'(hb[c-1]) : 32'd0);
    chk("g_rnd", 32'(g_rnd), (c >= 1 && iss[c-1]) ? 32'(hr[c-1]) : 32'd0);
    chk("g_ina", 32'(g_ina), (c >= 2 && iss[c-2]) ? 32'(ha[c-2]) : 32'd0);
    e_rv = (c >= 4) && iss[c-4];
    chk("resp_valid", 32'(resp_valid), 32'(e_rv));
    chk("resp_id", 32'(resp_id), e_rv ? 32'(gi[c-4]) : 32'd0);
    chk("resp_data", 32'(resp_data), e_rv ? 32'(hgo[c-1]) : 32'd0);
    if (e_rv) chk("resp_and", 32'(^resp_data), 32'((^ha[c-4]) & (^hb[c-4])));
    inf = 0;
    for (int k = 1; k <= 3; k++) if (c >= k && iss[c-k]) inf++;
    chk("inflight", 32'(inflight), 32'(inf));
    iss[c] = e_iss;
    gi[c]  = e_iss ? g : 0;
    ha[c]  = e_iss ? req_a[g*D +: D] : '0;
    hb[c]  = e_iss ? req_b[g*D +: D] : '0;
    hr[c]  = rnd_data;
    hgo[c] = g_out;
    oa[c]  = g_ina;
    ob[c]  = g_inb;
    if (e_iss) ptr = (g + 1) % NQ;
    if (r) begin
      ptr = 0;
      for (int k = 0; k <= 4; k++) if (c >= k) iss[c-k] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    rnd_valid = 1'b0; rnd_data = '0; g_out = '0;
    @(negedge clk);
    @(negedge clk);
    // Reset state
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b1111, 1'b1);
    // Single issue from requester 0 and its full latency
    step(1'b0, 4'b0001, 1'b1);
    repeat (5) step(1'b0, 4'b0000, 1'b0);
    // All requesting, continuous randomness
    repeat (8) step(1'b0, 4'b1111, 1'b1);
    repeat (4) step(1'b0, 4'b0000, 1'b0);
    // Two contenders held
    repeat (8) step(1'b0, 4'b0110, 1'b1);
    repeat (4) step(1'b0, 4'b0000, 1'b0);
    // Randomness starved, then supplied
    repeat (3) step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 1'b1);
    repeat (5) step(1'b0, 4'b0000, 1'b0);
    // Reset with two operations in flight
    repeat (2) step(1'b0, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    repeat (5) step(1'b0, 4'b0000, 1'b0);
    // Random traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      logic [NQ-1:0] rv;
      logic          rr;
      logic          rd;
      rv = NQ'($urandom);
      if ($urandom_range(0, 4) == 0) rv = '0;
      rd = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 59) == 0);
      step(rr, rv, rd);
    end
    repeat (5) step(1'b0, 4'b0000, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
